// File: rtl/uart_loader.sv
// UART boot loader: receives a little-endian 32-bit length followed by that many bytes over 8N1
// serial, writes them to program memory from address 0, then releases the core from reset.
module uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MEM_BYTES    = 4096,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {LdHdr, LdLoad, LdRun, LdError} ld_state_e;

  // Two-flop synchronizer; resets to the idle (high) line level.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver
  rx_state_e       rx_state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  logic half_end, bit_end;
  logic start_det, glitch, byte_stb, ferr_stb;

  assign half_end  = (baud_cnt_q == CntW'(HalfBit - 1));
  assign bit_end   = (baud_cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign start_det = (rx_state_q == RxIdle) && !rx_sync_q;
  assign glitch    = (rx_state_q == RxStart) && half_end && rx_sync_q;
  assign byte_stb  = (rx_state_q == RxStop) && bit_end && rx_sync_q;
  assign ferr_stb  = (rx_state_q == RxStop) && bit_end && !rx_sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          if (!rx_sync_q) rx_state_q <= RxStart;
        end
        RxStart: begin
          if (half_end) begin
            baud_cnt_q <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q  <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            rx_state_q <= RxIdle;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Loader
  ld_state_e         ld_state_q;
  logic [1:0]        hdr_cnt_q;
  logic [31:0]       len_q;
  logic [ADDR_W:0]   cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              core_reset_n_q, busy_q, done_q, err_q;
  logic [31:0]       hdr_len;

  // Length as it will read once the byte now completing is shifted in.
  assign hdr_len = {shift_q, len_q[31:8]};

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_state_q     <= LdHdr;
      hdr_cnt_q      <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      core_reset_n_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (ld_state_q)
        LdHdr: begin
          if (start_det) busy_q <= 1'b1;
          // A rejected glitch before any header byte does not count as a load.
          if (glitch && hdr_cnt_q == 2'd0) busy_q <= 1'b0;
          if (ferr_stb) begin
            ld_state_q <= LdError;
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
          end else if (byte_stb) begin
            len_q     <= hdr_len;
            hdr_cnt_q <= hdr_cnt_q + 1'b1;
            if (hdr_cnt_q == 2'd3) begin
              if (hdr_len == 32'd0) begin
                ld_state_q     <= LdRun;
                core_reset_n_q <= 1'b1;
                done_q         <= 1'b1;
                busy_q         <= 1'b0;
              end else if (hdr_len > 32'(MEM_BYTES)) begin
                ld_state_q <= LdError;
                err_q      <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                ld_state_q <= LdLoad;
                cnt_q      <= '0;
              end
            end
          end
        end
        LdLoad: begin
          if (32'(cnt_q) == len_q) begin
            ld_state_q     <= LdRun;
            core_reset_n_q <= 1'b1;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
          end else if (ferr_stb) begin
            ld_state_q <= LdError;
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
          end else if (byte_stb) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cnt_q[ADDR_W-1:0];
            mem_wdata_q <= shift_q;
            cnt_q       <= cnt_q + 1'b1;
          end
        end
        LdRun: begin
          core_reset_n_q <= 1'b1;
          done_q         <= 1'b1;
        end
        LdError: begin
          core_reset_n_q <= 1'b0;
          err_q          <= 1'b1;
        end
        default: ld_state_q <= LdError;
      endcase
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_reset_n = core_reset_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
